// File: rtl/alu_pkg.sv
// Shared opcode and FSM definitions for the multi-cycle ALU and its decoder.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_ILL = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_seq.sv
// Bit-serial shifter: loads an operand and count, then moves one bit per enabled cycle, zero-filled.
module alu_shift_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [4:0]       load_cnt,
    input  logic             shift_en,
    input  logic             dir_right,
    output logic [WIDTH-1:0] value,
    output logic             cnt_last
);

    logic [WIDTH-1:0] value_q, value_d;
    logic [4:0]       cnt_q, cnt_d;

    always_comb begin
        value_d = value_q;
        cnt_d   = cnt_q;
        if (load) begin
            value_d = load_val;
            cnt_d   = load_cnt;
        end else if (shift_en && (cnt_q != '0)) begin
            value_d = dir_right ? (value_q >> 1) : (value_q << 1);
            cnt_d   = cnt_q - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            cnt_q   <= '0;
        end else begin
            value_q <= value_d;
            cnt_q   <= cnt_d;
        end
    end

    // The final shift and the move to DONE happen on the same edge.
    assign value    = value_q;
    assign cnt_last = (cnt_q == 5'd1);

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops, bit-serial shifts, valid/ready on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);

    alu_state_e state_q, state_d;

    logic [WIDTH-1:0] alu_q, alu_d;
    logic             shift_sel_q, shift_sel_d;
    logic             dir_q, dir_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;

    logic             accept;
    logic             start_shift;
    logic [WIDTH-1:0] sum, diff, alu_val;
    logic             alu_ovf;
    logic [WIDTH-1:0] shift_val;
    logic             cnt_last;

    assign accept      = in_valid && (state_q == ST_IDLE);
    assign start_shift = is_shift_op(alucontrol) && (shamt != '0);
    assign sum         = a + b;
    assign diff        = a - b;

    always_comb begin
        alu_val = '0;
        alu_ovf = 1'b0;
        unique case (alucontrol)
            ALU_ADD: begin
                alu_val = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                alu_val = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: alu_val = a & b;
            ALU_OR:  alu_val = a | b;
            ALU_SLT: alu_val[0] = ($signed(a) < $signed(b));
            ALU_SLL, ALU_SRL: alu_val = a;
            ALU_ILL: alu_val = '0;
            default: alu_val = '0;
        endcase
    end

    alu_shift_seq #(.WIDTH(WIDTH)) u_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && start_shift),
        .load_val  (a),
        .load_cnt  (shamt),
        .shift_en  (state_q == ST_SHIFT),
        .dir_right (dir_q),
        .value     (shift_val),
        .cnt_last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid) state_d = start_shift ? ST_SHIFT : ST_DONE;
            ST_SHIFT: if (cnt_last) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        alu_d       = alu_q;
        shift_sel_d = shift_sel_q;
        dir_d       = dir_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        if (accept) begin
            alu_d       = alu_val;
            shift_sel_d = start_shift;
            dir_d       = (alucontrol == ALU_SRL);
            ovf_d       = alu_ovf;
            ill_d       = (alucontrol == ALU_ILL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q       <= '0;
            shift_sel_q <= 1'b0;
            dir_q       <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
        end else begin
            alu_q       <= alu_d;
            shift_sel_q <= shift_sel_d;
            dir_q       <= dir_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
        end
    end

    // Result is a mux of two registers, so zero still derives only from flopped state.
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        overflow  = (state_q == ST_DONE) && ovf_q;
        illegal   = (state_q == ST_DONE) && ill_q;
        result    = shift_sel_q ? shift_val : alu_q;
        zero      = (result == '0);
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed corner cases followed by randomized operations.
module tb_alu_mc;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ov;
        logic        il;
        int          lat;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alucontrol = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [4:0]  shamt = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    exp_t sbq[$];
    bit hold_mode = 1'b0;

    alu_mc #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .shamt      (shamt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] xa,
                                   input logic [31:0] xb, input logic [4:0] sh);
        exp_t   m;
        longint sa = longint'($signed(xa));
        longint sb = longint'($signed(xb));
        longint r  = 0;
        m.res = '0;
        m.ov  = 1'b0;
        m.il  = 1'b0;
        case (op)
            ALU_ADD: r = sa + sb;
            ALU_SUB: r = sa - sb;
            default: r = 0;
        endcase
        case (op)
            ALU_ADD, ALU_SUB: begin
                m.res = r[31:0];
                m.ov  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            ALU_AND: m.res = xa & xb;
            ALU_OR:  m.res = xa | xb;
            ALU_SLT: m.res = (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLL: m.res = xa << sh;
            ALU_SRL: m.res = xa >> sh;
            default: begin
                m.res = '0;
                m.il  = 1'b1;
            end
        endcase
        m.z   = (m.res == 32'd0);
        m.lat = ((op == ALU_SLL || op == ALU_SRL) && sh != 0) ? int'(sh) + 1 : 1;
        m.acc = 0;
        return m;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] xa,
                         input logic [31:0] xb, input logic [4:0] sh);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready %b expected 1", in_ready);
            return;
        end
        alucontrol = op;
        a          = xa;
        b          = xb;
        shamt      = sh;
        in_valid   = 1'b1;
        e          = model(op, xa, xb, sh);
        e.acc      = cyc + 1;
        sbq.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard when a result appears and keeps checking it while held.
    bit          seen = 1'b0;
    bit          expect_idle = 1'b0;
    int          done_cnt = 0;
    logic [31:0] held_res = '0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            seen        = 1'b0;
            expect_idle = 1'b0;
        end else begin
            if (expect_idle) begin
                chk("idle_after_handshake", 32'(in_ready), 32'd1);
                expect_idle = 1'b0;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_valid: out_valid 1 expected 0, result %h", result);
                    end else begin
                        e = sbq.pop_front();
                        chk("result", result, e.res);
                        chk("zero", 32'(zero), 32'(e.z));
                        chk("overflow", 32'(overflow), 32'(e.ov));
                        chk("illegal", 32'(illegal), 32'(e.il));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat - 1));
                    end
                    held_res = result;
                    seen     = 1'b1;
                    done_cnt = 0;
                end else begin
                    done_cnt++;
                    chk("hold_result", result, held_res);
                    chk("hold_in_ready", 32'(in_ready), 32'd0);
                end
                out_ready = hold_mode ? (done_cnt >= 5) : ($urandom_range(0, 3) != 0);
                if (out_ready) begin
                    seen        = 1'b0;
                    expect_idle = 1'b1;
                end
            end else begin
                chk("flags_outside_done", {30'd0, overflow, illegal}, 32'd0);
                out_ready = ($urandom_range(0, 1) != 0);
            end
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_zero", 32'(zero), 32'd1);
        chk("reset_flags", {30'd0, overflow, illegal}, 32'd0);

        issue(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        issue(ALU_SUB, 32'd5, 32'd5, 5'd0);
        issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, 5'd0);
        issue(ALU_SLL, 32'h0000_0001, 32'd0, 5'd31);
        issue(ALU_SRL, 32'h1234_5678, 32'd0, 5'd0);
        issue(ALU_ILL, 32'hDEAD_BEEF, 32'h1, 5'd3);
        issue(ALU_SUB, 32'h8000_0000, 32'd1, 5'd0);

        // Hold the result for 5 cycles while pulsing in_valid; none of it may be captured.
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        hold_mode = 1'b1;
        issue(ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A, 5'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        alucontrol = ALU_ADD;
        a          = 32'h1111_1111;
        b          = 32'h2222_2222;
        in_valid   = 1'b1;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        hold_mode = 1'b0;

        // Reset during the third shift cycle aborts the operation silently.
        issue(ALU_SRL, 32'hF000_0000, 32'd0, 5'd8);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        void'(sbq.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_result", result, 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        repeat (12) @(negedge clk);

        for (int i = 0; i < 80; i++) begin
            logic [2:0]  op;
            logic [4:0]  sh;
            logic [31:0] xa, xb;
            op = 3'($urandom_range(0, 7));
            xa = pick_operand();
            xb = pick_operand();
            sh = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
            issue(op, xa, xb, sh);
        end

        n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(sbq.size()), 32'd0);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
